// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: accepts single-word CPU requests over valid/ready,
// drives the memory command/address/data, captures read data and returns a
// response. Addresses with the device-select bit (MSB) set are unmapped and
// answered with an error without touching memory.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request, req_ready high
// WRITE   | single MWRITE cycle, memory commits at its closing edge
// READ    | MREAD held for READ_LAT+1 cycles, data captured on the last
// RESP    | response held until the consumer takes it
module mem_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int READ_LAT = 1   // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] MREAD  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MNONE  = 2'b10;

  // Counter compare value; 3 bits covers the whole legal latency range.
  localparam logic [2:0] LAT_TC = 3'(READ_LAT);

  logic [1:0] state;
  logic [2:0] wait_cnt;
  logic       accept;

  // A request is taken only while idle and ready.
  assign accept = req_valid & req_ready;

  // Main sequencer; every output is a register so memory and consumer see
  // glitch-free, edge-aligned signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_addr[ADDR_W-1]) begin
              // Unmapped: answer directly, memory-side outputs untouched.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write) begin
              state      <= S_WRITE;
              mem_cmd    <= MWRITE;
              mem_addr   <= req_addr;
              write_data <= req_wdata;
            end else begin
              state    <= S_READ;
              mem_cmd  <= MREAD;
              mem_addr <= req_addr;
              wait_cnt <= '0;
            end
          end
        end

        S_WRITE: begin
          state      <= S_RESP;
          mem_cmd    <= MNONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        S_READ: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_cnt == LAT_TC) begin
            state      <= S_RESP;
            mem_cmd    <= MNONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= data_out;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          mem_cmd   <= MNONE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
